// File: rtl/btn_scan_ctrl_if.sv
// Button scan bundle: raw button inputs in, debounced levels and edge strobes out.
// Latency: none, this is wiring only.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
// Signals: btn (raw async inputs), btn_level (debounced level), btn_press /
//   btn_release (one-cycle strobes), scan_busy (scan in progress),
//   overrun (sticky, a tick was dropped during a scan).
interface btn_scan_ctrl_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             scan_busy;
  logic             overrun;

  // master: the button/consumer side; slave: the scan controller
  modport master (
    output btn,
    input  btn_level, btn_press, btn_release, scan_busy, overrun
  );

  modport slave (
    input  btn,
    output btn_level, btn_press, btn_release, scan_busy, overrun
  );
endinterface

// File: rtl/btn_scan_ctrl.sv
// Shared debounce engine: one sample/compare datapath time-multiplexed over N_BTN buttons.
// Latency: 2 clk sync + wait for tick + STABLE_CNT ticks + (i+1) slot cycles for channel i.
// Backpressure: none; a tick that lands mid-scan is dropped and flagged sticky in overrun.
// Ports: clk, rst (async active-high), bus (slave modport: btn in; btn_level,
//   btn_press, btn_release, scan_busy, overrun out; all outputs registered).
module btn_scan_ctrl #(
  parameter int N_BTN      = 2,
  parameter int TICK_DIV   = 4,
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  btn_scan_ctrl_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [TW-1:0]    tick_cnt_q;
  logic             tick;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [N_BTN-1:0] level_q, press_q, release_q;
  logic             busy_q, overrun_q;

  // Slot datapath for the channel currently addressed by idx_q
  logic             svc_same;
  logic             svc_flip;
  logic [CNT_W-1:0] cnt_d;

  // Two-flop synchronizer per button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.btn;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler: tick is high on the last count of each TICK_DIV period
  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    svc_same = (sync2_q[idx_q] == level_q[idx_q]);
    cnt_d    = cnt_q[idx_q] + 1'b1;
    // Flip once this sample would make STABLE_CNT consecutive disagreements
    svc_flip = !svc_same && (cnt_d == CNT_W'(STABLE_CNT));
  end

  // Scan FSM plus the per-channel debounce state it services
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // Strobes are single-cycle by construction: cleared every edge unless re-set below
      press_q   <= '0;
      release_q <= '0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          // A tick mid-scan is dropped; the current scan runs to completion
          if (tick) begin
            overrun_q <= 1'b1;
          end
          if (svc_same) begin
            cnt_q[idx_q] <= '0;
          end else if (svc_flip) begin
            level_q[idx_q] <= ~level_q[idx_q];
            cnt_q[idx_q]   <= '0;
            if (level_q[idx_q]) begin
              release_q[idx_q] <= 1'b1;
            end else begin
              press_q[idx_q] <= 1'b1;
            end
          end else begin
            cnt_q[idx_q] <= cnt_d;
          end
          if (idx_q == IW'(N_BTN - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.scan_busy   = busy_q;
  assign bus.overrun     = overrun_q;

endmodule
